// File: rtl/pipe_skid_buffer.sv
// Two-entry registered skid buffer between pipeline stages (main + skid).
// Define PIPE_PERF_EN to add the saturating stall_cnt performance counter.
module pipe_skid_buffer #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int FSIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] in_data,
  input  logic [ASIZE-1:0] in_addr,
  input  logic [FSIZE-1:0] in_flags,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  output logic [ASIZE-1:0] out_addr,
  output logic [FSIZE-1:0] out_flags,
  input  logic             out_ready
`ifdef PIPE_PERF_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int W = DSIZE + ASIZE + FSIZE;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   main_q;
  logic [W-1:0]   skid_q;
  logic [W-1:0]   in_pl;
  logic           accept;
  logic           emit;

  assign in_pl  = {in_data, in_addr, in_flags};
  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // Handshake flags are kept as flops alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_q    <= in_pl;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_q <= in_pl;
          end else if (accept) begin
            skid_q   <= in_pl;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (emit) begin
            main_q    <= '0;
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (emit) begin
            main_q   <= skid_q;
            skid_q   <= '0;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          main_q    <= '0;
          skid_q    <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign {out_data, out_addr, out_flags} = main_q;

`ifdef PIPE_PERF_EN
  // Flush intentionally leaves the counter alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed and queue-model checks for pipe_skid_buffer.
// Perf counter checks run only when PIPE_PERF_EN is defined.
module tb_pipe_skid_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic [4:0]  in_addr;
  logic [3:0]  in_flags;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_addr;
  logic [3:0]  out_flags;
  logic        out_ready;
`ifdef PIPE_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int checks;
  int failures;

  pipe_skid_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_flags  (in_flags),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_flags (out_flags),
    .out_ready (out_ready)
`ifdef PIPE_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_addr   = '0;
    in_flags  = '0;
    out_ready = 1'b0;
  endtask

  logic [40:0] q[$];
  logic [40:0] pl;
  logic        acc;
  logic        emt;

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
`ifdef PIPE_PERF_EN
    chk("rst_stall", stall_cnt, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Streaming 1..8
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'd1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, k);
      chk("stream_ready", in_ready, 1);
      in_data = k + 1;
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain", out_valid, 0);
    chk("stream_zero", out_data, 0);

    // Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    in_addr   = 5'd3;
    in_flags  = 4'h5;
    step();
    in_data = 32'hB;
    step();
    in_valid = 1'b0;
    chk("bp_full_ready", in_ready, 0);
    chk("bp_hold_data", out_data, 32'hA);
    chk("bp_hold_addr", out_addr, 5'd3);
    chk("bp_hold_flags", out_flags, 4'h5);
    step();
    chk("bp_still_held", out_data, 32'hA);
    out_ready = 1'b1;
    step();
    chk("bp_second", out_data, 32'hB);
    chk("bp_ready_back", in_ready, 1);
    step();
    chk("bp_empty", out_valid, 0);

    // Flush from FULL with a colliding payload
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    in_data = 32'h22;
    step();
    in_data = 32'hC;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_data", out_data, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fl_no_c", out_valid, 0);
    end

    // Async reset while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h33;
    step();
    in_data = 32'h44;
    step();
    in_valid = 1'b0;
    chk("ar_pre_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_data", out_data, 0);
    chk("ar_ready", in_ready, 1);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h55;
    step();
    in_valid = 1'b0;
    chk("ar_first_acc", out_valid, 1);
    chk("ar_first_data", out_data, 32'h55);

`ifdef PIPE_PERF_EN
    out_ready = 1'b0;
    for (int k = 0; k < 70000; k++) @(posedge clk);
    #1;
    chk("perf_sat", stall_cnt, 16'hFFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("perf_keep", stall_cnt, 16'hFFFF);
`endif

    // Random against a reference queue
    idle();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      in_data   = c;
      in_addr   = 5'($urandom);
      in_flags  = 4'($urandom);
      acc = in_valid && (q.size() < 2);
      emt = out_ready && (q.size() > 0);
      step();
      if (flush) begin
        q.delete();
      end else begin
        if (emt) void'(q.pop_front());
        if (acc) q.push_back({in_data, in_addr, in_flags});
      end
      chk("rnd_valid", out_valid, q.size() > 0);
      chk("rnd_ready", in_ready, q.size() < 2);
      pl = (q.size() > 0) ? q[0] : '0;
      chk("rnd_head", {out_data, out_addr, out_flags}, pl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_buffer.md
PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

Interface
REQ-001 Parameter DSIZE, default 32, SHALL set the width of the result/operand data field.
REQ-002 Parameter ASIZE, default 5, SHALL set the width of the destination register address field.
REQ-003 Parameter FSIZE, default 4, SHALL set the width of the flags field.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 flush  input  1  SHALL be a synchronous pipeline flush request.
REQ-007 in_valid  input  1  SHALL indicate the upstream stage presents a payload.
REQ-008 in_data  input  DSIZE  SHALL be the upstream data payload.
REQ-009 in_addr  input  ASIZE  SHALL be the upstream destination address.
REQ-010 in_flags  input  FSIZE  SHALL be the upstream flags.
REQ-011 in_ready  output  1  SHALL indicate the block accepts a payload this cycle.
REQ-012 out_valid  output  1  SHALL indicate a payload is presented downstream.
REQ-013 out_data  output  DSIZE  SHALL be the head payload data.
REQ-014 out_addr  output  ASIZE  SHALL be the head destination address.
REQ-015 out_flags  output  FSIZE  SHALL be the head flags.
REQ-016 out_ready  input  1  SHALL indicate the downstream stage consumes the head this cycle.
REQ-017 stall_cnt  output  16  SHALL be present only when PIPE_PERF_EN is defined (REQ-035).

Function
REQ-018 An accept SHALL occur on a rising edge where in_valid and in_ready are both high; an emit SHALL occur where out_valid and out_ready are both high.
REQ-019 Storage SHALL be two entries, main (drives out_*) and skid, held in a three-state FSM: EMPTY, ONE, FULL.
REQ-020 All outputs SHALL be registered; there SHALL be no combinational path from out_ready to in_ready or from in_* to out_*.
REQ-021 in_ready SHALL be high exactly when the state is not FULL.
REQ-022 out_valid SHALL be high exactly when the state is ONE or FULL.
REQ-023 Latency from accept into EMPTY to out_valid high SHALL be one cycle.
REQ-024 EMPTY with accept SHALL load main and go to ONE.
REQ-025 ONE with accept and emit SHALL load main with the new payload and stay in ONE.
REQ-026 ONE with accept and no emit SHALL load skid and go to FULL.
REQ-027 ONE with emit and no accept SHALL go to EMPTY.
REQ-028 FULL with emit SHALL move skid into main and go to ONE; no accept is possible in FULL.
REQ-029 Without emit, FULL and ONE SHALL hold out_* stable.
REQ-030 Payloads SHALL emerge in strict acceptance order, with none dropped or duplicated except by flush.
REQ-031 flush SHALL take priority over accept and emit in the same cycle: next state is EMPTY, and any incoming payload is discarded.
REQ-032 out_data, out_addr and out_flags SHALL be zero whenever the state is EMPTY.

Reset
REQ-033 Asserting rst_n low SHALL immediately force EMPTY, with in_ready=1, out_valid=0, out_data/out_addr/out_flags=0 and stall_cnt=0, including mid-transfer.
REQ-034 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-035 With macro PIPE_PERF_EN defined:
- stall_cnt SHALL count cycles where out_valid=1 and out_ready=0.
- It SHALL saturate at 16'hFFFF.
- It SHALL be cleared only by reset, not by flush.
REQ-036 Without PIPE_PERF_EN, the stall_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-037 Streaming: send in_data 1..8 back-to-back with out_ready=1 -> out_data 1..8 on consecutive cycles, each one cycle after its accept, and in_ready stays 1.
REQ-038 Backpressure: with out_ready=0, accept A then B -> state FULL, in_ready=0, out_data=A held; raise out_ready -> A then B emitted, and in_ready returns to 1 one cycle after A's emit.
REQ-039 Flush: in FULL, assert flush with in_valid=1 and data C -> next cycle out_valid=0, in_ready=1, and C is never emitted.
REQ-040 Async reset: drop rst_n between clock edges while FULL -> out_valid=0 and out_data=0 before the next edge.
REQ-041 Perf counter (PIPE_PERF_EN defined): hold out_valid=1 and out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; a following flush leaves stall_cnt at 16'hFFFF.
REQ-042 Random test: random in_valid, out_ready and flush over 10000 cycles, checked against a reference queue model -> zero ordering or data mismatches.
